// File: rtl/powlib_vldrcv.sv
// Receive endpoint for a valid-only powlib stream; optional drop counter via POWLIB_VLDRCV_DROPCNT_EN.
// Latency: a word pushed at edge N is visible on q/qvld right after edge N; it cannot be popped until N+1.
// Backpressure: none upstream; words are dropped when full with no pop, downstream pops on qvld && rdy.
module powlib_vldrcv #(
   parameter int W   = 8,
   parameter int D   = 4,
   parameter int AFT = 3,
   parameter int CW  = $clog2(D) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  d,
   input  logic          vld,
   output logic [W-1:0]  q,
   output logic          qvld,
   input  logic          rdy,
   output logic [CW-1:0] cnt,
   output logic          afull,
   output logic          ovf,
   input  logic          clr
`ifdef POWLIB_VLDRCV_DROPCNT_EN
   ,
   output logic [15:0]   dropcnt
`endif
);

   localparam int PW = $clog2(D);
   localparam logic [CW-1:0] DEPTH  = CW'(D);
   localparam logic [CW-1:0] AFT_TH = CW'(AFT);

   if (D < 2 || (D & (D - 1)) != 0) begin : g_bad_depth
      $error("powlib_vldrcv: D must be a power of 2 and >= 2");
   end
   if (AFT < 1 || AFT > D) begin : g_bad_aft
      $error("powlib_vldrcv: AFT must be in 1..D");
   end

   logic [W-1:0]  mem [D];
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic          push;
   logic          pop;
   logic          drop;

   // A full buffer still accepts a word when the head leaves in the same cycle.
   assign qvld = (cnt != '0);
   assign pop  = qvld && rdy;
   assign push = vld && ((cnt < DEPTH) || pop);
   assign drop = vld && (cnt == DEPTH) && !pop;

   assign q     = qvld ? mem[rptr] : '0;
   assign afull = (cnt >= AFT_TH);

   // Storage is not reset; only words covered by cnt are ever observed.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr] <= d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) begin
            wptr <= wptr + PW'(1);
         end
         if (pop) begin
            rptr <= rptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // A drop in the same cycle as clr wins so no loss goes unreported.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf <= 1'b0;
      end else if (drop) begin
         ovf <= 1'b1;
      end else if (clr) begin
         ovf <= 1'b0;
      end
   end

`ifdef POWLIB_VLDRCV_DROPCNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dropcnt <= '0;
      end else if (clr) begin
         dropcnt <= drop ? 16'd1 : 16'd0;
      end else if (drop && dropcnt != 16'hFFFF) begin
         dropcnt <= dropcnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_powlib_vldrcv.sv
// Self-checking bench for powlib_vldrcv: directed scenarios plus a randomized run against a queue model.
module tb_powlib_vldrcv;

   localparam int W   = 8;
   localparam int D   = 4;
   localparam int AFT = 3;
   localparam int CW  = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [W-1:0]  d = '0;
   logic          vld = 1'b0;
   logic          rdy = 1'b0;
   logic          clr = 1'b0;
   logic [W-1:0]  q;
   logic          qvld;
   logic [CW-1:0] cnt;
   logic          afull;
   logic          ovf;
`ifdef POWLIB_VLDRCV_DROPCNT_EN
   logic [15:0]   dropcnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model: an ordered list of buffered words plus drop bookkeeping.
   logic [W-1:0] mq[$];
   logic         m_ovf = 1'b0;
   int           m_drops = 0;
   int           m_dropcnt = 0;

   powlib_vldrcv #(.W(W), .D(D), .AFT(AFT)) dut (
      .clk   (clk),
      .rst   (rst),
      .d     (d),
      .vld   (vld),
      .q     (q),
      .qvld  (qvld),
      .rdy   (rdy),
      .cnt   (cnt),
      .afull (afull),
      .ovf   (ovf),
      .clr   (clr)
`ifdef POWLIB_VLDRCV_DROPCNT_EN
      ,
      .dropcnt (dropcnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      mq.delete();
      m_ovf     = 1'b0;
      m_dropcnt = 0;
   endtask

   task automatic model_step(input logic v, input logic [W-1:0] dd, input logic r, input logic c);
      bit popped, dropped;
      popped  = (mq.size() != 0) && r;
      dropped = v && (mq.size() == D) && !popped;
      if (popped) void'(mq.pop_front());
      if (v && !dropped) mq.push_back(dd);
      if (dropped) begin
         m_drops++;
         m_ovf = 1'b1;
      end else if (c) begin
         m_ovf = 1'b0;
      end
      if (c) m_dropcnt = dropped ? 1 : 0;
      else if (dropped && m_dropcnt < 65535) m_dropcnt++;
   endtask

   task automatic tick(input logic v, input logic [W-1:0] dd, input logic r, input logic c);
      vld = v; d = dd; rdy = r; clr = c;
      @(posedge clk);
      model_step(v, dd, r, c);
      #1;
      vld = 1'b0; rdy = 1'b0; clr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      #12;
      checks++;
      if ({q, qvld, cnt, afull, ovf} !== '0) begin
         errors++;
         $display("FAIL reset_hold: got q=%h qvld=%b cnt=%0d afull=%b ovf=%b, want all 0", q, qvld, cnt, afull, ovf);
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      tick(1'b0, '0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      checks++;
      if ({q, qvld, cnt, afull, ovf} !== '0) begin
         errors++;
         $display("FAIL reset_idle: got q=%h qvld=%b cnt=%0d afull=%b ovf=%b, want all 0", q, qvld, cnt, afull, ovf);
      end
`ifdef POWLIB_VLDRCV_DROPCNT_EN
      checks++;
      if (dropcnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_dropcnt: got %0d want 0", dropcnt);
      end
`endif
   endtask

   task automatic test_fill_drain();
      logic [W-1:0] words [4];
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
      for (int i = 0; i < 4; i++) begin
         tick(1'b1, words[i], 1'b0, 1'b0);
         checks++;
         if (cnt !== CW'(i + 1) || afull !== (i + 1 >= AFT) || q !== 8'h11 || qvld !== 1'b1) begin
            errors++;
            $display("FAIL fill_%0d: got cnt=%0d afull=%b q=%h qvld=%b, want cnt=%0d afull=%b q=11 qvld=1",
                     i, cnt, afull, q, qvld, i + 1, (i + 1 >= AFT));
         end
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q !== words[i] || qvld !== 1'b1) begin
            errors++;
            $display("FAIL drain_%0d: got q=%h qvld=%b, want q=%h qvld=1", i, q, qvld, words[i]);
         end
         tick(1'b0, '0, 1'b1, 1'b0);
      end
      checks++;
      if (qvld !== 1'b0 || cnt !== '0 || q !== '0) begin
         errors++;
         $display("FAIL drain_empty: got qvld=%b cnt=%0d q=%h, want 0 0 00", qvld, cnt, q);
      end
   endtask

   task automatic test_overflow();
      for (int i = 1; i <= 4; i++) tick(1'b1, W'(i), 1'b0, 1'b0);
      tick(1'b1, 8'h55, 1'b0, 1'b0);
      checks++;
      if (ovf !== 1'b1 || cnt !== CW'(4) || q !== 8'h01) begin
         errors++;
         $display("FAIL overflow_drop: got ovf=%b cnt=%0d q=%h, want ovf=1 cnt=4 q=01", ovf, cnt, q);
      end
`ifdef POWLIB_VLDRCV_DROPCNT_EN
      checks++;
      if (dropcnt !== 16'd1) begin
         errors++;
         $display("FAIL overflow_dropcnt: got %0d want 1", dropcnt);
      end
`endif
      tick(1'b0, '0, 1'b0, 1'b1);
      checks++;
      if (ovf !== 1'b0 || cnt !== CW'(4)) begin
         errors++;
         $display("FAIL overflow_clr: got ovf=%b cnt=%0d, want ovf=0 cnt=4", ovf, cnt);
      end
`ifdef POWLIB_VLDRCV_DROPCNT_EN
      checks++;
      if (dropcnt !== 16'd0) begin
         errors++;
         $display("FAIL overflow_clr_dropcnt: got %0d want 0", dropcnt);
      end
`endif
      // Drop and clr together: the drop must be the one that sticks.
      tick(1'b1, 8'h77, 1'b0, 1'b1);
      checks++;
      if (ovf !== 1'b1) begin
         errors++;
         $display("FAIL clr_vs_drop: got ovf=%b want 1", ovf);
      end
`ifdef POWLIB_VLDRCV_DROPCNT_EN
      checks++;
      if (dropcnt !== 16'd1) begin
         errors++;
         $display("FAIL clr_vs_drop_dropcnt: got %0d want 1", dropcnt);
      end
`endif
      tick(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_full_push_pop();
      logic [W-1:0] exp_seq [4];
      exp_seq[0] = 8'h02; exp_seq[1] = 8'h03; exp_seq[2] = 8'h04; exp_seq[3] = 8'h66;
      tick(1'b1, 8'h66, 1'b1, 1'b0);
      checks++;
      if (ovf !== 1'b0 || cnt !== CW'(4)) begin
         errors++;
         $display("FAIL full_push_pop: got ovf=%b cnt=%0d, want ovf=0 cnt=4", ovf, cnt);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (q !== exp_seq[i]) begin
            errors++;
            $display("FAIL full_drain_%0d: got q=%h want %h", i, q, exp_seq[i]);
         end
         tick(1'b0, '0, 1'b1, 1'b0);
      end
      checks++;
      if (qvld !== 1'b0) begin
         errors++;
         $display("FAIL full_drain_empty: got qvld=%b want 0", qvld);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, W'(i), 1'b1, 1'b0);
         checks++;
         if (cnt !== CW'(1) || q !== W'(i) || qvld !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d: got cnt=%0d q=%h qvld=%b, want cnt=1 q=%h qvld=1", i, cnt, q, qvld, W'(i));
         end
      end
      checks++;
      if (ovf !== 1'b0) begin
         errors++;
         $display("FAIL b2b_ovf: got %b want 0", ovf);
      end
      tick(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset_midburst();
      for (int i = 0; i < 3; i++) tick(1'b1, W'(8'hA0 + i), 1'b0, 1'b0);
      tick(1'b1, 8'hEE, 1'b1, 1'b1);
      checks++;
      if (cnt !== CW'(3)) begin
         errors++;
         $display("FAIL midburst_pre: got cnt=%0d want 3", cnt);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({q, qvld, cnt, afull, ovf} !== '0) begin
         errors++;
         $display("FAIL midburst_async_reset: got q=%h qvld=%b cnt=%0d afull=%b ovf=%b, want all 0", q, qvld, cnt, afull, ovf);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      tick(1'b1, 8'h5A, 1'b0, 1'b0);
      checks++;
      if (q !== 8'h5A || cnt !== CW'(1)) begin
         errors++;
         $display("FAIL after_reset_push: got q=%h cnt=%0d, want q=5a cnt=1", q, cnt);
      end
      tick(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_random();
      int rdy_pct;
      int start_drops;
      logic v, r, c;
      logic [W-1:0] dd;
      logic [W-1:0] exp_q;
      start_drops = m_drops;
      for (int n = 0; n < 10000; n++) begin
         if (n % 500 == 0) rdy_pct = $urandom_range(20, 95);
         v  = ($urandom_range(0, 99) < 60);
         r  = ($urandom_range(0, 99) < rdy_pct);
         c  = ($urandom_range(0, 63) == 0);
         dd = W'($urandom);
         tick(v, dd, r, c);
         exp_q = (mq.size() != 0) ? mq[0] : '0;
         checks++;
         if (q !== exp_q || qvld !== (mq.size() != 0) || cnt !== CW'(mq.size())
             || afull !== (mq.size() >= AFT) || ovf !== m_ovf) begin
            errors++;
            $display("FAIL random_%0d: got q=%h qvld=%b cnt=%0d afull=%b ovf=%b, want q=%h qvld=%b cnt=%0d afull=%b ovf=%b",
                     n, q, qvld, cnt, afull, ovf, exp_q, (mq.size() != 0), mq.size(), (mq.size() >= AFT), m_ovf);
         end
`ifdef POWLIB_VLDRCV_DROPCNT_EN
         checks++;
         if (dropcnt !== 16'(m_dropcnt)) begin
            errors++;
            $display("FAIL random_dropcnt_%0d: got %0d want %0d", n, dropcnt, m_dropcnt);
         end
`endif
      end
      checks++;
      if (m_drops == start_drops) begin
         errors++;
         $display("FAIL random_coverage: got 0 drops, want at least 1");
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_async_reset_midburst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
